exec_unit_mc: RTL and testbench

- Parametrised execute stage for the 5-stage pipeline, sitting between decode and memory.
- Replaces the fixed 16-bit single-cycle ALU with a width-generic ALU, a valid/ready handshake in both directions, and an iterative multi-cycle signed multiplier.
- Back-pressures decode while a multiply is in flight or memory is stalled.

---
 rtl/exec_unit_mc_if.sv | 47 ++++
 rtl/exec_unit_mc.sv | 126 ++++++++++++
 tb/tb_exec_unit_mc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_mc_if.sv
// Decode-side request and memory-side response bundle for exec_unit_mc.
// Optional flags output is present only when EXEC_FLAGS_EN is defined.
interface exec_unit_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int SB_WIDTH   = 32
);
  // Valid/ready: a beat transfers on the active clock edge where valid && ready;
  // the source holds its payload stable while valid && !ready, and ready never
  // depends on the same-side valid.
  logic                  req_valid;
  logic                  req_ready;
  logic [3:0]            op;
  logic                  use_imm;
  logic [DATA_WIDTH-1:0] src1;
  logic [DATA_WIDTH-1:0] src2;
  logic [DATA_WIDTH-1:0] imm;
  logic [IDX_WIDTH-1:0]  dest;
  logic [SB_WIDTH-1:0]   sideband;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [IDX_WIDTH-1:0]  rsp_dest;
  logic [SB_WIDTH-1:0]   rsp_sideband;
  logic                  busy;
  logic [1:0]            fsm_state;
`ifdef EXEC_FLAGS_EN
  logic [2:0]            nzp;
`endif

  modport slave (
    input  req_valid, op, use_imm, src1, src2, imm, dest, sideband, rsp_ready,
    output req_ready, rsp_valid, result, rsp_dest, rsp_sideband, busy, fsm_state
`ifdef EXEC_FLAGS_EN
    , output nzp
`endif
  );

  modport master (
    output req_valid, op, use_imm, src1, src2, imm, dest, sideband, rsp_ready,
    input  req_ready, rsp_valid, result, rsp_dest, rsp_sideband, busy, fsm_state
`ifdef EXEC_FLAGS_EN
    , input nzp
`endif
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Execute stage: single-cycle ALU plus iterative radix-2 multiplier, state on the falling edge.
// Define EXEC_FLAGS_EN to add the registered {N,Z,P} flags output.
module exec_unit_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4,
  parameter int SB_WIDTH   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_unit_mc_if.slave  bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] opb, alu_res, load_val;
  logic [SHW-1:0]        shamt;
  logic [DATA_WIDTH-1:0] acc, mcand, mplier;
  logic [SHW-1:0]        cnt;
  logic [IDX_WIDTH-1:0]  m_dest, load_dest;
  logic [SB_WIDTH-1:0]   m_sb, load_sb;
  logic                  accept, is_mul, load_alu, load_mul;

  assign opb   = bus.use_imm ? bus.imm : bus.src2;
  assign shamt = opb[SHW-1:0];

  assign bus.req_ready = (state == IDLE) && (!bus.rsp_valid || bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;
  assign is_mul        = (bus.op == 4'd8);
  assign load_alu      = accept && !is_mul;
  // The multiplier result only needs a free (or draining) output register.
  assign load_mul      = (state == DONE) && (!bus.rsp_valid || bus.rsp_ready);
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      4'd0:    alu_res = bus.src1 + opb;
      4'd1:    alu_res = bus.src1 - opb;
      4'd2:    alu_res = bus.src1 & opb;
      4'd3:    alu_res = bus.src1 | opb;
      4'd4:    alu_res = bus.src1 ^ opb;
      4'd5:    alu_res = opb;
      4'd6:    alu_res = bus.src1 << shamt;
      4'd7:    alu_res = $signed(bus.src1) >>> shamt;
      4'd9:    alu_res = bus.src1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nx = MUL;
      MUL:     if (cnt == LAST_STEP) state_nx = DONE;
      DONE:    if (load_mul)         state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Low DATA_WIDTH bits of a two's-complement product equal those of the
  // unsigned product, so a plain shift-add over all bits is exact.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      m_dest <= '0;
      m_sb   <= '0;
    end else if (state == IDLE) begin
      if (accept && is_mul) begin
        acc    <= '0;
        mcand  <= bus.src1;
        mplier <= opb;
        cnt    <= '0;
        m_dest <= bus.dest;
        m_sb   <= bus.sideband;
      end
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign load_val  = load_alu ? alu_res  : acc;
  assign load_dest = load_alu ? bus.dest : m_dest;
  assign load_sb   = load_alu ? bus.sideband : m_sb;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid    <= 1'b0;
      bus.result       <= '0;
      bus.rsp_dest     <= '0;
      bus.rsp_sideband <= '0;
    end else if (load_alu || load_mul) begin
      bus.rsp_valid    <= 1'b1;
      bus.result       <= load_val;
      bus.rsp_dest     <= load_dest;
      bus.rsp_sideband <= load_sb;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid    <= 1'b0;
    end
  end

`ifdef EXEC_FLAGS_EN
  logic flag_n, flag_z;
  assign flag_n = load_val[DATA_WIDTH-1];
  assign flag_z = (load_val == '0);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)                     bus.nzp <= 3'b010;
    else if (load_alu || load_mul)  bus.nzp <= {flag_n, flag_z, !flag_n && !flag_z};
  end
`endif
endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: directed cases plus randomized traffic against a latency/arithmetic model.
// Flags are compared as well when EXEC_FLAGS_EN is defined.
module tb_exec_unit_mc;
  localparam int W   = 16;
  localparam int IW  = 4;
  localparam int SBW = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  bit   run_cmp;

  exec_unit_mc_if #(.DATA_WIDTH(W), .IDX_WIDTH(IW), .SB_WIDTH(SBW)) bus ();

  exec_unit_mc #(.DATA_WIDTH(W), .IDX_WIDTH(IW), .SB_WIDTH(SBW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock/reset: DUT acts on the falling edge, bench compares on the rising edge
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  // behavioural model: output register plus a pending product with a countdown
  bit            m_valid;
  logic [W-1:0]  m_res;
  logic [IW-1:0] m_dest;
  logic [SBW-1:0] m_sb;
  logic [2:0]    m_nzp;
  bit            m_busy;
  int            m_cnt;
  logic [W-1:0]  m_prod;
  logic [IW-1:0] m_pdest;
  logic [SBW-1:0] m_psb;
  bit            m_last_acc;

  function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sh;
    logic [W-1:0] r;
    sh = int'(b % W);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return b;
      6: return a << sh;
      7: begin
        r = a;
        for (int i = 0; i < sh; i++) r = {r[W-1], r[W-1:1]};
        return r;
      end
      9: return a;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed(a) * $signed(b);
    return p[W-1:0];
  endfunction

  function automatic logic [2:0] ref_nzp(input logic [W-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == '0)        return 3'b010;
    return 3'b001;
  endfunction

  function automatic bit model_ready();
    return !m_busy && (!m_valid || bus.rsp_ready);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = '0; m_dest = '0; m_sb = '0; m_nzp = 3'b010;
    m_busy = 0; m_cnt = 0; m_prod = '0; m_pdest = '0; m_psb = '0; m_last_acc = 0;
  endtask

  task automatic model_step();
    bit ld;
    bit acc;
    logic [W-1:0] v, b;
    logic [IW-1:0] d;
    logic [SBW-1:0] s;
    ld = 0; v = '0; d = '0; s = '0;
    acc = bus.req_valid && model_ready();
    b = bus.use_imm ? bus.imm : bus.src2;
    if (m_busy) begin
      if (m_cnt > 0) m_cnt--;
      else if (!m_valid || bus.rsp_ready) begin
        ld = 1; v = m_prod; d = m_pdest; s = m_psb; m_busy = 0;
      end
    end else if (acc) begin
      if (bus.op == 4'd8) begin
        m_busy = 1; m_cnt = W; m_prod = ref_mul(bus.src1, b);
        m_pdest = bus.dest; m_psb = bus.sideband;
      end else begin
        ld = 1; v = ref_alu(int'(bus.op), bus.src1, b); d = bus.dest; s = bus.sideband;
      end
    end
    if (ld) begin
      m_valid = 1; m_res = v; m_dest = d; m_sb = s; m_nzp = ref_nzp(v);
    end else if (bus.rsp_ready) begin
      m_valid = 0;
    end
    m_last_acc = acc;
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    if (rst_n) model_step();
    #2;
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input bit ui, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] im, input logic [IW-1:0] d,
                       input logic [SBW-1:0] s);
    bus.req_valid = v; bus.op = op; bus.use_imm = ui; bus.src1 = a;
    bus.src2 = b; bus.imm = im; bus.dest = d; bus.sideband = s;
  endtask

  task automatic idle();
    drive(0, 4'd0, 0, '0, '0, '0, '0, '0);
  endtask

  task automatic drive_random();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 5) == 0) op = 4'd8;
    drive($urandom_range(0, 3) != 0, op, $urandom_range(0, 1) == 1, W'($urandom), W'($urandom),
          W'($urandom), IW'($urandom), $urandom);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every rising edge the DUT outputs must match the model
  always @(posedge clk) begin
    logic [63:0] act, exp;
    if (run_cmp) begin
      act = {6'd0, bus.rsp_valid, bus.result, bus.rsp_dest, bus.rsp_sideband, bus.busy, bus.req_ready, 3'd0};
      exp = {6'd0, m_valid, m_res, m_dest, m_sb, m_busy, model_ready(), 3'd0};
`ifdef EXEC_FLAGS_EN
      act[2:0] = bus.nzp;
      exp[2:0] = m_nzp;
`endif
      check("cycle_cmp", act, exp);
    end
  end

  initial begin
    n_vec = 0; n_bad = 0; run_cmp = 0;
    rst_n = 0;
    bus.rsp_ready = 1;
    idle();
    model_reset();
    run_cmp = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;

    check("reset_valid", bus.rsp_valid, 0);
    check("reset_result", bus.result, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ready", bus.req_ready, 1);
`ifdef EXEC_FLAGS_EN
    check("reset_nzp", bus.nzp, 3'b010);
`endif

    // ADD overflow then SUB underflow, back to back
    drive(1, 4'd0, 0, 16'h7FFF, 16'h0001, '0, 4'd3, 32'h1111_0000);
    tick();
    check("add_model", m_res, 16'h8000);
    check("add_result", bus.result, 16'h8000);
    check("add_dest", bus.rsp_dest, 4'd3);
`ifdef EXEC_FLAGS_EN
    check("add_nzp", bus.nzp, 3'b100);
`endif
    drive(1, 4'd1, 0, 16'h0000, 16'h0001, '0, 4'd4, 32'h2222_0000);
    tick();
    check("sub_result", bus.result, 16'hFFFF);
    check("sub_valid", bus.rsp_valid, 1);
`ifdef EXEC_FLAGS_EN
    check("sub_nzp", bus.nzp, 3'b100);
`endif
    idle();
    tick();

    // MUL -3 * 5: busy for W+1 edges, result after edge N+W+1
    drive(1, 4'd8, 0, 16'hFFFD, 16'h0005, '0, 4'd7, 32'h3333_0000);
    tick();
    idle();
    check("mul_busy_0", bus.busy, 1);
    check("mul_ready_0", bus.req_ready, 0);
    for (int i = 1; i <= W; i++) begin
      tick();
      check("mul_busy", bus.busy, 1);
      check("mul_ready", bus.req_ready, 0);
      check("mul_novalid", bus.rsp_valid, 0);
    end
    tick();
    check("mul_model", m_res, 16'hFFF1);
    check("mul_result", bus.result, 16'hFFF1);
    check("mul_done_busy", bus.busy, 0);
    check("mul_dest", bus.rsp_dest, 4'd7);

    // ADDI then stall with a second op waiting
    drive(1, 4'd0, 1, 16'd10, 16'h1234, 16'hFFFC, 4'd1, 32'h4444_0000);
    tick();
    check("addi_result", bus.result, 16'd6);
    bus.rsp_ready = 0;
    drive(1, 4'd4, 0, 16'h00F0, 16'h0FF0, '0, 4'd2, 32'h5555_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", bus.result, 16'd6);
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1;
    #1 check("release_ready", bus.req_ready, 1);
    tick();
    check("release_load", bus.result, 16'h0F00);
    check("release_dest", bus.rsp_dest, 4'd2);

    // shifts and an undefined op carrying its sideband
    drive(1, 4'd7, 0, 16'h8000, 16'h0013, '0, 4'd5, 32'h6666_0000);
    tick();
    check("sra_result", bus.result, 16'hF000);
    drive(1, 4'd6, 0, 16'h0001, 16'h000F, '0, 4'd6, 32'h7777_0000);
    tick();
    check("sll_result", bus.result, 16'h8000);
    drive(1, 4'd12, 0, 16'h1234, 16'h5678, '0, 4'd9, 32'hDEAD_BEEF);
    tick();
    check("op12_result", bus.result, 16'h0000);
    check("op12_sideband", bus.rsp_sideband, 32'hDEAD_BEEF);
    idle();
    tick();

    // MUL finishing while memory is stalled
    drive(1, 4'd8, 0, 16'd7, 16'hFFFE, '0, 4'd8, 32'h8888_0000);
    tick();
    idle();
    bus.rsp_ready = 0;
    repeat (W) tick();
    check("mulst_busy", bus.busy, 1);
    tick();
    check("mulst_result", bus.result, 16'hFFF2);
    check("mulst_valid", bus.rsp_valid, 1);
    tick();
    check("mulst_hold", bus.result, 16'hFFF2);
    bus.rsp_ready = 1;
    tick();
    check("mulst_retire", bus.rsp_valid, 0);

    // reset in the middle of a multiply
    drive(1, 4'd8, 0, 16'd7, 16'd3, '0, 4'd2, 32'h9999_0000);
    tick();
    idle();
    repeat (5) tick();
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid_valid", bus.rsp_valid, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_ready", bus.req_ready, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (W + 4) tick();
    check("rst_mid_noresult", bus.rsp_valid, 0);

    // randomized traffic, holding an offered op until it is taken
    drive_random();
    for (int i = 0; i < 600; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (!bus.req_valid || m_last_acc) drive_random();
    end

    idle();
    bus.rsp_ready = 1;
    repeat (W + 4) tick();
    run_cmp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
